// File: rtl/rotate_amount_finder.sv
// rotate_amount_finder
//
// Sequential inverse of the 8-bit rotator. Given an original byte `a` and a
// candidate byte `y`, it walks one right-rotation step per clock and reports
// whether `y` is a rotation of `a`, and by what amount and direction.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   request, sampled only while not busy
//   a          in   original byte, captured on accepted start
//   y          in   target byte, captured on accepted start
//   busy       out  search in progress
//   done       out  one-cycle pulse, result valid
//   found      out  y is a rotation of a
//   amt        out  rotation amount (0..7)
//   direction  out  1 = rotate right, 0 = rotate left
//
// Build option:
//   ROTFIND_SHORTEST_EN  report the shortest rotation: right by k for k<=4,
//                        left by 8-k otherwise. Without it, always right by k.
//
// Only the target byte is kept after acceptance. The working register starts
// as a copy of `a` and is rotated in place, so no separate copy of `a` is needed.

module rotate_amount_finder (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] y,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic [2:0] amt,
    output logic       direction
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_reg;
    logic [7:0]  y_reg;      // captured target
    logic [7:0]  w_reg;      // working copy of a, rotated right k times
    logic [2:0]  k_reg;      // current step
    logic [7:0]  w_rot;      // w_reg rotated right by one
    logic [2:0]  res_amt;    // encoded amount for a match at k_reg
    logic        res_dir;    // encoded direction for a match at k_reg

    // Right rotation by one: bit 0 wraps into bit 7.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign w_rot[gi] = w_reg[(gi + 1) % 8];
        end
    endgenerate

`ifdef ROTFIND_SHORTEST_EN
    // Steps 5..7 to the right are shorter as 3..1 steps to the left.
    always_comb begin
        res_amt = k_reg;
        res_dir = 1'b1;
        if (k_reg > 3'd4) begin
            res_amt = 3'd0 - k_reg;  // 8 - k in 3 bits
            res_dir = 1'b0;
        end
    end
`else
    always_comb begin
        res_amt = k_reg;
        res_dir = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            y_reg     <= 8'd0;
            w_reg     <= 8'd0;
            k_reg     <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            amt       <= 3'd0;
            direction <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    // DONE accepts start directly, giving back-to-back searches.
                    if (start) begin
                        y_reg     <= y;
                        w_reg     <= a;
                        k_reg     <= 3'd0;
                        busy      <= 1'b1;
                        state_reg <= SEARCH;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                SEARCH: begin
                    if (w_reg == y_reg) begin
                        // First match wins: smallest right rotation.
                        found     <= 1'b1;
                        amt       <= res_amt;
                        direction <= res_dir;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else if (k_reg == 3'd7) begin
                        found     <= 1'b0;
                        amt       <= 3'd0;
                        direction <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        w_reg <= w_rot;
                        k_reg <= k_reg + 3'd1;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
